imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Registered, parametrised immediate generator for the decode stage of the 16-bit core. Extracts and zero/sign-extends the immediate field of the current instruction to `DATA_W` under a mode select, and additionally handles the EXTEND prefix: a prefix instruction is captured and merged with the following instruction into a full 16-bit immediate. Sits between the IF/ID register and the ID/EX register; its output is valid one cycle after the instruction is presented. It obeys the pipeline's stall and flush controls.

## Interface
- `DATA_W`, 16, output immediate width; legal range 16..32.
- `EXT_EN`, 1, 1 enables EXTEND-prefix handling; 0 treats the EXTEND opcode as an ordinary instruction.
- `EXT_OP`, 5'b11110, opcode in `inst[15:11]` that marks an EXTEND prefix.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst`  in  16  instruction word from IF/ID.
- `inst_valid`  in  1  `inst` is a real instruction this cycle.
- `mode`  in  3  immediate kind for `inst`: 0 Z8, 1 S11, 2 S8, 3 S5, 4 S4, 5 NONE; 6 and 7 behave as NONE.
- `stall`  in  1  hold all state; ignore `inst`.
- `flush`  in  1  discard in-flight output and any pending prefix.
- `imm`  out  `DATA_W`  extended immediate.
- `imm_valid`  out  1  `imm` corresponds to a retired non-prefix instruction.
- `ext_pending`  out  1  a prefix is captured and awaiting its partner.
- `ext_err`  out  1  one-cycle pulse: prefix followed by another prefix.

## Operation
- Non-extended extraction: Z8 = zero-extend `inst[7:0]`; S11 = sign-extend `inst[10:0]`; S8 = sign-extend `inst[7:0]`; S5 = sign-extend `inst[4:0]`; S4 = sign-extend `inst[3:0]`; NONE = all zeros.
- Prefix detect: `inst_valid & EXT_EN & inst[15:11]==EXT_OP`. On accept: store `inst[10:0]` in prefix register, set `ext_pending`, drive `imm_valid`=0 next cycle (`imm` holds previous value).
- Extended instruction (accepted non-prefix while `ext_pending`=1): imm16 = {pre[4:0], pre[10:5], inst[4:0]}; zero-extend to `DATA_W` for Z8, sign-extend (bit 15) for S11/S8/S5/S4, zeros for NONE. Clears `ext_pending`; `imm_valid`=1.
- Prefix while pending: new prefix replaces old, `ext_pending` stays 1, `ext_err` pulses for one cycle.
- `inst_valid`=0 with no stall: `imm_valid`=0 next cycle; `ext_pending` and prefix unchanged (bubbles between prefix and partner are legal).
- FSM: IDLE (no prefix) and PEND (prefix held). IDLE→PEND on accepted prefix; PEND→IDLE on accepted non-prefix or flush; PEND→PEND on prefix (with `ext_err`); any→IDLE on `rst`.

## Timing
- Latency: 1 cycle from accepted `inst` to `imm`/`imm_valid`.
- Priority per edge: `rst` > `flush` > `stall` > normal accept.
- `flush`: next cycle `imm_valid`=0, `ext_pending`=0, `ext_err`=0; `imm` value unchanged; `inst` that cycle is dropped even if valid.
- `stall` (without flush): all registers hold, including `imm_valid` and `ext_err` (an `ext_err` already high stays high for the stalled cycles).
- Reset values: `imm`=0, `imm_valid`=0, `ext_pending`=0, `ext_err`=0, prefix register=0.
- Reset asserted mid-PEND: prefix discarded; next instruction is treated as non-extended.
- `EXT_EN`=0: `ext_pending` and `ext_err` tied 0; block is a registered extender only.

## Structure
- Mode encodings (`IMM_Z8`..`IMM_NONE`), `EXT_OP` default, and 16-bit instruction width go in the shared define package alongside the existing bus-width macros.
- One natural sub-module: `imm_ext_comb` — purely combinational field select and extend (inputs `inst`, `mode`, `ext_hit`, `pre`); top level holds FSM and output registers.

## Test plan
- Reset then `inst`=16'h00F5, mode S8, valid → next cycle `imm`=16'hFFF5, `imm_valid`=1; mode Z8 → 16'h00F5.
- DATA_W=32, `inst`=16'h0410, mode S11 → `imm`=32'hFFFFFC10; mode S4 same inst → 32'h00000000.
- Prefix 16'hF7E3 (pre=11'h7E3) then `inst`=16'h0015 mode S5 → cycle 1 `imm_valid`=0, `ext_pending`=1; cycle 2 `imm`=16'h1FF5 ({00011,111111,10101}), `imm_valid`=1, `ext_pending`=0. With pre=11'h7FF → 16'hFFF5, sign-extended to 32'hFFFFFFF5 at DATA_W=32, zero-extended for Z8.
- Prefix, two bubbles, stall 3 cycles, partner → `ext_pending` holds throughout; partner produces extended imm.
- Prefix then prefix → `ext_err` high one cycle, second prefix used; prefix then `flush` with valid partner → partner dropped, `ext_pending`=0, `imm_valid`=0.
- `stall` and `flush` together while PEND → flush wins; `rst` mid-PEND then 16'h0015 S5 → `imm`=16'hFFF5 (non-extended).

Source files
------------

// File: rtl/imm_ext_pipe_pkg.sv
// Shared definitions for the decode-stage immediate generator.
//   INST_W            : instruction word width of the 16-bit core
//   DATA_W_MIN/MAX    : legal range of the extended immediate bus
//   EXT_OP_DEF        : default opcode (inst[15:11]) of the EXTEND prefix
//   imm_mode_e        : immediate kind selected by the decoder
//   ext_state_e       : prefix-tracking FSM states
package imm_ext_pipe_pkg;

    localparam int INST_W     = 16;
    localparam int DATA_W_MIN = 16;
    localparam int DATA_W_MAX = 32;
    localparam int PRE_W      = 11;

    localparam logic [4:0] EXT_OP_DEF = 5'b11110;

    // Encodings 6 and 7 are unused and decode as NONE.
    typedef enum logic [2:0] {
        IMM_Z8   = 3'd0,
        IMM_S11  = 3'd1,
        IMM_S8   = 3'd2,
        IMM_S5   = 3'd3,
        IMM_S4   = 3'd4,
        IMM_NONE = 3'd5
    } imm_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ext_state_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational field select and extend.
//   inst_i    : low 11 bits of the instruction (the opcode field is not needed here)
//   mode_i    : immediate kind (imm_mode_e encoding, 6/7 act as NONE)
//   ext_hit_i : a prefix is pending, so merge it with inst_i
//   pre_i     : captured prefix payload
//   imm_o     : extended immediate, DATA_W bits
module imm_ext_comb
    import imm_ext_pipe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [PRE_W-1:0]  inst_i,
    input  logic [2:0]        mode_i,
    input  logic              ext_hit_i,
    input  logic [PRE_W-1:0]  pre_i,
    output logic [DATA_W-1:0] imm_o
);

    // Prefix payload is stored in instruction-field order; the merged
    // immediate reassembles it as {pre[4:0], pre[10:5], inst[4:0]}.
    logic [15:0] ext16;
    assign ext16 = {pre_i[4:0], pre_i[10:5], inst_i[4:0]};

    // Size casts of signed operands sign-extend, of unsigned ones zero-extend.
    always_comb begin
        imm_o = '0;
        if (ext_hit_i) begin
            case (mode_i)
                IMM_Z8:                          imm_o = DATA_W'(ext16);
                IMM_S11, IMM_S8, IMM_S5, IMM_S4: imm_o = DATA_W'($signed(ext16));
                default:                         imm_o = '0;
            endcase
        end else begin
            case (mode_i)
                IMM_Z8:  imm_o = DATA_W'(inst_i[7:0]);
                IMM_S11: imm_o = DATA_W'($signed(inst_i[10:0]));
                IMM_S8:  imm_o = DATA_W'($signed(inst_i[7:0]));
                IMM_S5:  imm_o = DATA_W'($signed(inst_i[4:0]));
                IMM_S4:  imm_o = DATA_W'($signed(inst_i[3:0]));
                default: imm_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate generator with EXTEND-prefix merging (decode stage).
//   clk_i, rst_i      : clock, synchronous active-high reset
//   inst_i            : instruction word from IF/ID
//   inst_valid_i      : inst_i is a real instruction
//   mode_i            : immediate kind for inst_i
//   stall_i, flush_i  : pipeline hold / discard (flush wins over stall)
//   imm_o             : extended immediate, valid one cycle after accept
//   imm_valid_o       : imm_o belongs to a retired non-prefix instruction
//   ext_pending_o     : prefix captured, waiting for its partner
//   ext_err_o         : pulse when a prefix follows a prefix
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int         DATA_W = 16,
    parameter bit         EXT_EN = 1'b1,
    parameter logic [4:0] EXT_OP = EXT_OP_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              inst_valid_i,
    input  logic [2:0]        mode_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] imm_o,
    output logic              imm_valid_o,
    output logic              ext_pending_o,
    output logic              ext_err_o
);

    ext_state_e        state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DATA_W-1:0] imm_q, imm_d, imm_comb;
    logic              imm_valid_q, imm_valid_d;
    logic              ext_err_q, ext_err_d;
    logic              ext_en_w;
    logic              is_pre;
    logic              ext_hit;

    assign ext_en_w = EXT_EN;
    assign is_pre   = inst_valid_i & ext_en_w & (inst_i[15:11] == EXT_OP);
    assign ext_hit  = (state_q == ST_PEND);

    imm_ext_comb #(.DATA_W(DATA_W)) u_comb (
        .inst_i    (inst_i[PRE_W-1:0]),
        .mode_i    (mode_i),
        .ext_hit_i (ext_hit),
        .pre_i     (pre_q),
        .imm_o     (imm_comb)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; bubbles (inst_valid_i=0) leave the state alone
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else if (!stall_i) begin
            if (is_pre)            state_d = ST_PEND;
            else if (inst_valid_i) state_d = ST_IDLE;
        end
    end

    // Output / datapath next values
    always_comb begin
        pre_d       = pre_q;
        imm_d       = imm_q;
        imm_valid_d = imm_valid_q;
        ext_err_d   = ext_err_q;
        if (flush_i) begin
            // imm_o keeps its last value; only the qualifiers drop
            imm_valid_d = 1'b0;
            ext_err_d   = 1'b0;
        end else if (!stall_i) begin
            if (is_pre) begin
                pre_d       = inst_i[PRE_W-1:0];
                imm_valid_d = 1'b0;
                ext_err_d   = (state_q == ST_PEND);
            end else if (inst_valid_i) begin
                imm_d       = imm_comb;
                imm_valid_d = 1'b1;
                ext_err_d   = 1'b0;
            end else begin
                imm_valid_d = 1'b0;
                ext_err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q       <= '0;
            imm_q       <= '0;
            imm_valid_q <= 1'b0;
            ext_err_q   <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            imm_q       <= imm_d;
            imm_valid_q <= imm_valid_d;
            ext_err_q   <= ext_err_d;
        end
    end

    assign imm_o         = imm_q;
    assign imm_valid_o   = imm_valid_q;
    assign ext_pending_o = ext_en_w & (state_q == ST_PEND);
    assign ext_err_o     = ext_en_w & ext_err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;
    import imm_ext_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, inst_valid, stall, flush;
    logic [15:0] inst;
    logic [2:0]  mode;

    logic [15:0] imm_a, imm_c;
    logic [31:0] imm_b;
    logic        vld_a, vld_b, vld_c, pend_a, pend_b, pend_c, err_a, err_b, err_c;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    // Three views of the same stimulus: 16-bit, 32-bit, and prefix handling disabled.
    imm_ext_pipe #(.DATA_W(16), .EXT_EN(1'b1)) u16 (
        .clk_i(clk), .rst_i(rst), .inst_i(inst), .inst_valid_i(inst_valid), .mode_i(mode),
        .stall_i(stall), .flush_i(flush), .imm_o(imm_a), .imm_valid_o(vld_a),
        .ext_pending_o(pend_a), .ext_err_o(err_a));
    imm_ext_pipe #(.DATA_W(32), .EXT_EN(1'b1)) u32 (
        .clk_i(clk), .rst_i(rst), .inst_i(inst), .inst_valid_i(inst_valid), .mode_i(mode),
        .stall_i(stall), .flush_i(flush), .imm_o(imm_b), .imm_valid_o(vld_b),
        .ext_pending_o(pend_b), .ext_err_o(err_b));
    imm_ext_pipe #(.DATA_W(16), .EXT_EN(1'b0)) u16n (
        .clk_i(clk), .rst_i(rst), .inst_i(inst), .inst_valid_i(inst_valid), .mode_i(mode),
        .stall_i(stall), .flush_i(flush), .imm_o(imm_c), .imm_valid_o(vld_c),
        .ext_pending_o(pend_c), .ext_err_o(err_c));

    logic [31:0] d_imm [3];
    logic        d_vld [3], d_pend [3], d_err [3];
    assign d_imm[0] = {16'h0, imm_a};
    assign d_imm[1] = imm_b;
    assign d_imm[2] = {16'h0, imm_c};
    assign d_vld[0] = vld_a;  assign d_vld[1] = vld_b;  assign d_vld[2] = vld_c;
    assign d_pend[0] = pend_a; assign d_pend[1] = pend_b; assign d_pend[2] = pend_c;
    assign d_err[0] = err_a;  assign d_err[1] = err_b;  assign d_err[2] = err_c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int mw  [3] = '{16, 32, 16};
    bit men [3] = '{1'b1, 1'b1, 1'b0};
    logic        m_pend [3];
    logic [10:0] m_pre  [3];
    logic [31:0] m_imm  [3];
    logic        m_vld  [3], m_err [3];

    // Immediate as a signed integer, then truncated to the output width.
    function automatic logic [31:0] model_imm(input logic [15:0] i, input int md,
                                              input bit hit, input logic [10:0] p, input int w);
        longint v, raw;
        logic [63:0] mask;
        v = 0;
        if (hit) begin
            raw = longint'(p[4:0]) * 2048 + longint'(p[10:5]) * 32 + longint'(i[4:0]);
            if (md == 0) v = raw;
            else if (md >= 1 && md <= 4) v = (raw >= 32768) ? raw - 65536 : raw;
        end else begin
            case (md)
                0: v = longint'(i[7:0]);
                1: begin v = longint'(i[10:0]); if (v >= 1024) v -= 2048; end
                2: begin v = longint'(i[7:0]);  if (v >= 128)  v -= 256;  end
                3: begin v = longint'(i[4:0]);  if (v >= 16)   v -= 32;   end
                4: begin v = longint'(i[3:0]);  if (v >= 8)    v -= 16;   end
                default: v = 0;
            endcase
        end
        mask = (64'd1 << w) - 64'd1;
        return 32'(v & mask);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_pend[k] = 1'b0; m_pre[k] = '0; m_imm[k] = '0; m_vld[k] = 1'b0; m_err[k] = 1'b0;
            end else if (flush) begin
                m_pend[k] = 1'b0; m_vld[k] = 1'b0; m_err[k] = 1'b0;
            end else if (!stall) begin
                if (inst_valid && men[k] && inst[15:11] == 5'b11110) begin
                    m_err[k]  = m_pend[k];
                    m_pend[k] = 1'b1;
                    m_pre[k]  = inst[10:0];
                    m_vld[k]  = 1'b0;
                end else if (inst_valid) begin
                    m_imm[k]  = model_imm(inst, int'(mode), m_pend[k], m_pre[k], mw[k]);
                    m_vld[k]  = 1'b1;
                    m_err[k]  = 1'b0;
                    m_pend[k] = 1'b0;
                end else begin
                    m_vld[k] = 1'b0;
                    m_err[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("imm[%0d]", k),  d_imm[k],        m_imm[k]);
                chk($sformatf("vld[%0d]", k),  32'(d_vld[k]),   32'(m_vld[k]));
                chk($sformatf("pend[%0d]", k), 32'(d_pend[k]),  32'(m_pend[k]));
                chk($sformatf("err[%0d]", k),  32'(d_err[k]),   32'(m_err[k]));
            end
        end
    end

    // Drive one cycle at a negedge; returns at the next negedge with outputs settled.
    task automatic cyc(input logic [15:0] i, input logic [2:0] m, input logic v,
                       input logic s, input logic f, input logic r);
        inst = i; mode = m; inst_valid = v; stall = s; flush = f; rst = r;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] ri;
        rst = 1'b1; inst = '0; mode = '0; inst_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_imm32", imm_b, 32'h0);
        chk("rst_vld",   32'(vld_a), 32'h0);
        chk("rst_pend",  32'(pend_a), 32'h0);
        chk("rst_err",   32'(err_a), 32'h0);

        chk("mdl_ext_pin", model_imm(16'h0015, 3, 1'b1, 11'h7E3, 16), 32'h1FF5);
        chk("mdl_s11_pin", model_imm(16'h0410, 1, 1'b0, 11'h0, 32), 32'hFFFFFC10);

        cyc(16'h00F5, IMM_S8, 1, 0, 0, 0);
        chk("s8_imm", 32'(imm_a), 32'hFFF5); chk("s8_vld", 32'(vld_a), 32'h1);
        cyc(16'h00F5, IMM_Z8, 1, 0, 0, 0);
        chk("z8_imm", 32'(imm_a), 32'h00F5);
        cyc(16'h0410, IMM_S11, 1, 0, 0, 0);
        chk("s11_imm32", imm_b, 32'hFFFFFC10);
        cyc(16'h0410, IMM_S4, 1, 0, 0, 0);
        chk("s4_imm32", imm_b, 32'h0);

        cyc(16'hF7E3, IMM_S5, 1, 0, 0, 0);
        chk("pre_vld", 32'(vld_a), 32'h0); chk("pre_pend", 32'(pend_a), 32'h1);
        chk("pre_imm_hold", 32'(imm_a), 32'h0);
        chk("noext_imm", 32'(imm_c), 32'h0003); chk("noext_pend", 32'(pend_c), 32'h0);
        cyc(16'h0015, IMM_S5, 1, 0, 0, 0);
        chk("ext_imm16", 32'(imm_a), 32'h1FF5); chk("ext_imm32", imm_b, 32'h00001FF5);
        chk("ext_vld", 32'(vld_a), 32'h1); chk("ext_pend", 32'(pend_a), 32'h0);
        cyc(16'hF7FF, IMM_S5, 1, 0, 0, 0);
        cyc(16'h0015, IMM_S5, 1, 0, 0, 0);
        chk("ext7ff_16", 32'(imm_a), 32'hFFF5); chk("ext7ff_32", imm_b, 32'hFFFFFFF5);
        cyc(16'hF7FF, IMM_S5, 1, 0, 0, 0);
        cyc(16'h0015, IMM_Z8, 1, 0, 0, 0);
        chk("ext7ff_z8_32", imm_b, 32'h0000FFF5);

        cyc(16'hF7E3, IMM_S5, 1, 0, 0, 0);
        for (int n = 0; n < 2; n++) begin
            cyc(16'h0000, IMM_Z8, 0, 0, 0, 0);
            chk("bubble_pend", 32'(pend_a), 32'h1);
        end
        for (int n = 0; n < 3; n++) begin
            cyc(16'h1234, IMM_S8, 1, 1, 0, 0);
            chk("stall_pend", 32'(pend_a), 32'h1); chk("stall_vld", 32'(vld_a), 32'h0);
        end
        cyc(16'h0015, IMM_S5, 1, 0, 0, 0);
        chk("late_ext", 32'(imm_a), 32'h1FF5); chk("late_vld", 32'(vld_a), 32'h1);

        cyc(16'hF7E3, IMM_S5, 1, 0, 0, 0);
        cyc(16'hF7FF, IMM_S5, 1, 0, 0, 0);
        chk("err_hi", 32'(err_a), 32'h1); chk("err_pend", 32'(pend_a), 32'h1);
        cyc(16'hABCD, IMM_S5, 1, 1, 0, 0);
        chk("err_stall_hold", 32'(err_a), 32'h1);
        cyc(16'h0015, IMM_S5, 1, 0, 0, 0);
        chk("err_lo", 32'(err_a), 32'h0); chk("err_2nd_pre", 32'(imm_a), 32'hFFF5);

        cyc(16'hF7E3, IMM_S5, 1, 0, 0, 0);
        cyc(16'h0015, IMM_S5, 1, 0, 1, 0);
        chk("fl_pend", 32'(pend_a), 32'h0); chk("fl_vld", 32'(vld_a), 32'h0);
        chk("fl_imm_hold", 32'(imm_a), 32'hFFF5);
        cyc(16'hF7E3, IMM_S5, 1, 0, 0, 0);
        cyc(16'h0015, IMM_S5, 1, 1, 1, 0);
        chk("flst_pend", 32'(pend_a), 32'h0); chk("flst_vld", 32'(vld_a), 32'h0);
        cyc(16'h0015, IMM_S5, 1, 0, 0, 0);
        chk("flst_nonext", 32'(imm_a), 32'hFFF5);

        cyc(16'hF7E3, IMM_S5, 1, 0, 0, 0);
        cyc(16'h0000, IMM_Z8, 0, 0, 0, 1);
        chk("rstp_pend", 32'(pend_a), 32'h0); chk("rstp_imm", 32'(imm_a), 32'h0);
        cyc(16'h0015, IMM_S5, 1, 0, 0, 0);
        chk("rstp_nonext16", 32'(imm_a), 32'hFFF5); chk("rstp_nonext32", imm_b, 32'hFFFFFFF5);

        for (int n = 0; n < 3000; n++) begin
            ri = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ri[15:11] = 5'b11110;
            cyc(ri, 3'($urandom_range(0, 7)),
                ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
        end
        cyc(16'h0, IMM_Z8, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
